mipi_hs_burst_ctrl: RTL and testbench
=====================================

# mipi_hs_burst_ctrl

Per-lane HS burst sequencer that sits directly behind `mipi_byte_aligner` in the D-PHY protocol analyzer. It owns the aligner's `align_rst_n`: it arms the aligner at the start of each HS burst and holds it in reset between bursts. It then frames the aligned byte stream into DSI packets (header, payload, CRC) and presents header fields and payload bytes to the downstream packet logger.

## Interface
- `SYNC_TIMEOUT`, default 64: byte_clk cycles allowed in WAIT_SYNC before `sync_err`; range 1..65535.
- `byte_clk`  in  1  byte clock; all logic on its rising edge.
- `sys_rst_n`  in  1  asynchronous active-low reset.
- `hs_active`  in  1  lane in HS mode, synchronous to `byte_clk`; high for the whole burst.
- `aligned_valid`  in  1  `data_out_valid` from the aligner.
- `aligned_data`  in  8  `data_out` from the aligner.
- `align_rst_n`  out  1  drives the aligner's `align_rst_n`.
- `pkt_hdr_valid`  out  1  one-cycle strobe; header fields below are valid.
- `pkt_di`  out  8  data identifier (VC[7:6], DT[5:0]).
- `pkt_wc`  out  16  word count for long packets; `{data1,data0}` for short packets.
- `pkt_long`  out  1  header is a long packet.
- `ecc_err`  out  1  header ECC mismatch, qualified by `pkt_hdr_valid`.
- `pl_valid`  out  1  payload byte strobe.
- `pl_data`  out  8  payload byte.
- `pkt_end`  out  1  one-cycle strobe; packet complete (short: with header; long: after CRC byte 2).
- `pkt_crc`  out  16  received CRC `{crc_hi,crc_lo}`, valid with `pkt_end` for long packets.
- `pkt_abort`  out  1  one-cycle strobe; burst ended inside a long packet.
- `sync_err`  out  1  one-cycle strobe; no sync byte within `SYNC_TIMEOUT`.

## Operation
- States: IDLE, WAIT_SYNC, HDR, PAYLOAD, CRC, DONE.
- IDLE: `align_rst_n`=0. When `hs_active`=1, go to WAIT_SYNC.
- WAIT_SYNC: `align_rst_n`=1. The timeout counter increments each cycle.
  - First `aligned_valid` byte is the sync byte (0xB8). It is consumed, not output. Go to HDR.
  - If the counter reaches `SYNC_TIMEOUT`, pulse `sync_err` and go to DONE.
- HDR: collect 4 valid bytes: DI, WC_L, WC_H, ECC.
  - On the 4th byte, register the fields and pulse `pkt_hdr_valid`.
  - `pkt_long` = (DT[3:0] ∈ {4'h9, 4'hC, 4'hD, 4'hE}).
  - Short packet: pulse `pkt_end` in the same cycle as `pkt_hdr_valid`; stay in HDR for the next packet.
  - Long packet, WC=0: go to CRC.
  - Long packet, WC≠0: go to PAYLOAD.
- PAYLOAD: forward each valid byte to `pl_data`/`pl_valid`. A 16-bit down-counter is loaded with WC; go to CRC when it reaches 0.
- CRC: capture 2 valid bytes, pulse `pkt_end`, return to HDR.
- DONE: `align_rst_n`=0. Wait for `hs_active`=0, then go to IDLE.
- `hs_active`=0 in any state other than IDLE/DONE: go to IDLE next cycle.
  - From PAYLOAD or CRC, pulse `pkt_abort`.
  - From HDR with a partial header, discard silently.
  - Trailing EoT bytes therefore never generate strobes.
- Byte counters advance only on `aligned_valid`=1; gaps stall the state machine.
- CRC is captured, not checked.

## Timing
- Reset values: `align_rst_n`=0; all strobes=0; `pkt_di`/`pkt_wc`/`pkt_crc`/`pl_data`=0; `pkt_long`=0; `ecc_err`=0; state IDLE.
- `align_rst_n` is registered: it rises the cycle after `hs_active` is first sampled high, and falls the cycle after the exit condition.
- All outputs are registered. `pl_data` appears 1 cycle after the input byte. `pkt_hdr_valid` appears 1 cycle after the ECC byte.
- `hs_active` falling on the same edge as the last CRC byte: `pkt_end` wins; no `pkt_abort`.
- Asynchronous reset mid-packet: immediate return to reset values; no abort strobe.

## Configuration
- `MIPI_BURST_ECC_EN` defined:
  - Compute the DSI 6-bit Hamming ECC over `{WC_H,WC_L,DI}`.
  - Set `ecc_err` if it differs from ECC[5:0] or ECC[7:6]≠0.
  - No correction; framing uses the received WC regardless.
- Undefined: `ecc_err` is tied 0 and no ECC logic is synthesized.

## Structure
- Shared package `mipi_dsi_pkg`:
  - State enum.
  - `SYNC_BYTE_ALIGNED` = 8'hB8.
  - Long-type DT list.
  - ECC parity masks, shared with future TX blocks.
- Sub-module `mipi_dsi_ecc6`: combinational 24-bit to 6-bit ECC. Instantiated only under `MIPI_BURST_ECC_EN`.

## Test plan
- Burst with sync, then short packet DI=0x05, data 0x11,0x00, correct ECC → one `pkt_hdr_valid` with `pkt_wc`=0x0011, `pkt_long`=0, `pkt_end` in the same cycle.
- Long packet DI=0x39, WC=3, payload 0xAA,0xBB,0xCC, CRC 0x1234 → 3 `pl_valid` bytes in order, then `pkt_end` with `pkt_crc`=0x1234.
- Two back-to-back packets (short, then long WC=2) in one burst → two `pkt_end` strobes; no re-sync; `align_rst_n` stays high.
- `hs_active` drops after the 1st of 5 payload bytes → one `pkt_abort`; IDLE; `align_rst_n`=0 the next cycle.
- No valid byte for 64 cycles → `sync_err` at cycle 64; `align_rst_n` low until `hs_active` falls.
- With `MIPI_BURST_ECC_EN`, header with ECC bit 0 flipped → `ecc_err`=1 with `pkt_hdr_valid`; payload still forwarded per WC.

Source files
------------

// File: rtl/mipi_dsi_pkg.sv
// mipi_dsi_pkg: shared DSI definitions for the burst sequencer and future TX blocks.
package mipi_dsi_pkg;

    // Burst sequencer states
    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_WAIT_SYNC = 3'd1,
        ST_HDR       = 3'd2,
        ST_PAYLOAD   = 3'd3,
        ST_CRC       = 3'd4,
        ST_DONE      = 3'd5
    } burst_state_e;

    // Sync byte as it leaves the byte aligner
    localparam logic [7:0] SYNC_BYTE_ALIGNED = 8'hB8;

    // Low nibble of the data types that carry a word count and payload
    localparam logic [3:0] LONG_DT_LO [4] = '{4'h9, 4'hC, 4'hD, 4'hE};

    // DSI header ECC parity masks over {WC_H, WC_L, DI}; index i selects parity bit Pi
    localparam logic [5:0][23:0] ECC_MASKS = {
        24'hEFFC00,  // P5
        24'hDF03F0,  // P4
        24'hB8E38E,  // P3
        24'h749A6D,  // P2
        24'hF2555B,  // P1
        24'hF12CB7   // P0
    };

    // True when the data type low nibble marks a long packet
    function automatic logic is_long_dt(input logic [3:0] dt_lo);
        logic r;
        r = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (dt_lo == LONG_DT_LO[i]) r = 1'b1;
        end
        return r;
    endfunction

endpackage

// File: rtl/mipi_dsi_ecc6.sv
// mipi_dsi_ecc6: combinational DSI packet header ECC (24 data bits -> 6 parity bits).
module mipi_dsi_ecc6
    import mipi_dsi_pkg::*;
(
    input  logic [23:0] i_data,
    output logic [5:0]  o_ecc
);

    // Each parity bit is the XOR of the header bits picked out by its mask
    always_comb begin
        o_ecc = '0;
        for (int i = 0; i < 6; i++) begin
            o_ecc[i] = ^(i_data & ECC_MASKS[i]);
        end
    end

endmodule

// File: rtl/mipi_hs_burst_ctrl.sv
// mipi_hs_burst_ctrl: per-lane HS burst sequencer. Arms the byte aligner for each
// burst, then frames the aligned byte stream into DSI packets (header, payload, CRC).
// Build macro MIPI_BURST_ECC_EN enables header ECC checking; otherwise ecc_err is 0.
module mipi_hs_burst_ctrl
    import mipi_dsi_pkg::*;
#(
    parameter int unsigned SYNC_TIMEOUT = 64
) (
    input  logic        byte_clk,
    input  logic        sys_rst_n,
    input  logic        hs_active,
    input  logic        aligned_valid,
    input  logic [7:0]  aligned_data,
    output logic        align_rst_n,
    output logic        pkt_hdr_valid,
    output logic [7:0]  pkt_di,
    output logic [15:0] pkt_wc,
    output logic        pkt_long,
    output logic        ecc_err,
    output logic        pl_valid,
    output logic [7:0]  pl_data,
    output logic        pkt_end,
    output logic [15:0] pkt_crc,
    output logic        pkt_abort,
    output logic        sync_err
);

    localparam logic [15:0] SYNC_LAST = 16'(SYNC_TIMEOUT - 1);

    burst_state_e r_state, w_state_nxt;
    logic [15:0]  r_sync_cnt, r_pl_cnt;
    logic [1:0]   r_hdr_idx;
    logic         r_crc_idx;
    logic [7:0]   r_hdr_di, r_hdr_wcl, r_hdr_wch, r_crc_lo;
    logic [15:0]  w_wc;
    logic         w_long, w_hdr_done, w_crc_done, w_sync_to, w_active_nxt;
    logic         w_hdr_valid, w_end, w_pl_valid, w_abort, w_sync_err;

    logic         r_align_rst_n, r_pkt_hdr_valid, r_pkt_long, r_pl_valid;
    logic         r_pkt_end, r_pkt_abort, r_sync_err;
    logic [7:0]   r_pkt_di, r_pl_data;
    logic [15:0]  r_pkt_wc, r_pkt_crc;

    assign w_wc       = {r_hdr_wch, r_hdr_wcl};
    assign w_long     = is_long_dt(r_hdr_di[3:0]);
    assign w_hdr_done = aligned_valid && (r_hdr_idx == 2'd3);
    assign w_crc_done = aligned_valid && r_crc_idx;
    assign w_sync_to  = (r_sync_cnt == SYNC_LAST);

    // State register
    always_ff @(posedge byte_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) r_state <= ST_IDLE;
        else            r_state <= w_state_nxt;
    end

    // Next-state: byte-driven framing; hs_active low leaves any active state
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:      if (hs_active) w_state_nxt = ST_WAIT_SYNC;
            ST_WAIT_SYNC: begin
                if (!hs_active)         w_state_nxt = ST_IDLE;
                else if (aligned_valid) w_state_nxt = ST_HDR;
                else if (w_sync_to)     w_state_nxt = ST_DONE;
            end
            ST_HDR: begin
                if (!hs_active)       w_state_nxt = ST_IDLE;
                else if (w_hdr_done) begin
                    if (!w_long)            w_state_nxt = ST_HDR;
                    else if (w_wc == 16'd0) w_state_nxt = ST_CRC;
                    else                    w_state_nxt = ST_PAYLOAD;
                end
            end
            ST_PAYLOAD: begin
                if (!hs_active)                                w_state_nxt = ST_IDLE;
                else if (aligned_valid && r_pl_cnt == 16'd1) w_state_nxt = ST_CRC;
            end
            ST_CRC: begin
                if (!hs_active)      w_state_nxt = ST_IDLE;
                else if (w_crc_done) w_state_nxt = ST_HDR;
            end
            ST_DONE:      if (!hs_active) w_state_nxt = ST_IDLE;
            default:      w_state_nxt = ST_IDLE;
        endcase
    end

    // Output decode: a byte arriving as hs_active falls counts only if it completes a packet
    always_comb begin
        w_hdr_valid = 1'b0;
        w_end       = 1'b0;
        w_pl_valid  = 1'b0;
        w_abort     = 1'b0;
        w_sync_err  = 1'b0;
        case (r_state)
            ST_WAIT_SYNC: w_sync_err = hs_active && !aligned_valid && w_sync_to;
            ST_HDR: begin
                if (w_hdr_done && (hs_active || !w_long)) begin
                    w_hdr_valid = 1'b1;
                    w_end       = !w_long;
                end
            end
            ST_PAYLOAD: begin
                if (hs_active) w_pl_valid = aligned_valid;
                else           w_abort    = 1'b1;
            end
            ST_CRC: begin
                if (w_crc_done)      w_end   = 1'b1;
                else if (!hs_active) w_abort = 1'b1;
            end
            default: ;
        endcase
    end

    assign w_active_nxt = (w_state_nxt == ST_WAIT_SYNC) || (w_state_nxt == ST_HDR) ||
                          (w_state_nxt == ST_PAYLOAD)   || (w_state_nxt == ST_CRC);

    // Registered outputs: strobes every cycle, data fields held until next update
    always_ff @(posedge byte_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_align_rst_n   <= 1'b0;
            r_pkt_hdr_valid <= 1'b0;
            r_pkt_di        <= 8'd0;
            r_pkt_wc        <= 16'd0;
            r_pkt_long      <= 1'b0;
            r_pl_valid      <= 1'b0;
            r_pl_data       <= 8'd0;
            r_pkt_end       <= 1'b0;
            r_pkt_crc       <= 16'd0;
            r_pkt_abort     <= 1'b0;
            r_sync_err      <= 1'b0;
        end else begin
            r_align_rst_n   <= w_active_nxt;
            r_pkt_hdr_valid <= w_hdr_valid;
            r_pl_valid      <= w_pl_valid;
            r_pkt_end       <= w_end;
            r_pkt_abort     <= w_abort;
            r_sync_err      <= w_sync_err;
            if (w_hdr_valid) begin
                r_pkt_di   <= r_hdr_di;
                r_pkt_wc   <= w_wc;
                r_pkt_long <= w_long;
            end
            if (w_pl_valid) r_pl_data <= aligned_data;
            if (w_end && r_state == ST_CRC) r_pkt_crc <= {aligned_data, r_crc_lo};
        end
    end

    // Byte counters: advance only on valid bytes, cleared outside their state
    always_ff @(posedge byte_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_sync_cnt <= 16'd0;
            r_hdr_idx  <= 2'd0;
            r_crc_idx  <= 1'b0;
            r_pl_cnt   <= 16'd0;
        end else begin
            r_sync_cnt <= (r_state == ST_WAIT_SYNC) ? r_sync_cnt + 16'd1 : 16'd0;
            if (r_state != ST_HDR)  r_hdr_idx <= 2'd0;
            else if (aligned_valid) r_hdr_idx <= r_hdr_idx + 2'd1;
            if (r_state != ST_CRC)  r_crc_idx <= 1'b0;
            else if (aligned_valid) r_crc_idx <= ~r_crc_idx;
            if (r_state == ST_HDR && w_hdr_done)              r_pl_cnt <= w_wc;
            else if (r_state == ST_PAYLOAD && aligned_valid) r_pl_cnt <= r_pl_cnt - 16'd1;
        end
    end

    // Header and CRC byte capture (data path, no reset needed)
    always_ff @(posedge byte_clk) begin
        if (r_state == ST_HDR && aligned_valid) begin
            case (r_hdr_idx)
                2'd0:    r_hdr_di  <= aligned_data;
                2'd1:    r_hdr_wcl <= aligned_data;
                2'd2:    r_hdr_wch <= aligned_data;
                default: ;
            endcase
        end
        if (r_state == ST_CRC && aligned_valid && !r_crc_idx) r_crc_lo <= aligned_data;
    end

`ifdef MIPI_BURST_ECC_EN
    logic [5:0] w_ecc_calc;
    logic       w_ecc_bad;
    logic       r_ecc_err;

    mipi_dsi_ecc6 u_ecc6 (
        .i_data ({r_hdr_wch, r_hdr_wcl, r_hdr_di}),
        .o_ecc  (w_ecc_calc)
    );

    // ECC byte is on aligned_data in the cycle the header completes
    assign w_ecc_bad = (w_ecc_calc != aligned_data[5:0]) || (aligned_data[7:6] != 2'b00);

    // Header ECC flag, updated together with the other header fields
    always_ff @(posedge byte_clk or negedge sys_rst_n) begin
        if (!sys_rst_n)       r_ecc_err <= 1'b0;
        else if (w_hdr_valid) r_ecc_err <= w_ecc_bad;
    end

    assign ecc_err = r_ecc_err;
`else
    assign ecc_err = 1'b0;
`endif

    assign align_rst_n   = r_align_rst_n;
    assign pkt_hdr_valid = r_pkt_hdr_valid;
    assign pkt_di        = r_pkt_di;
    assign pkt_wc        = r_pkt_wc;
    assign pkt_long      = r_pkt_long;
    assign pl_valid      = r_pl_valid;
    assign pl_data       = r_pl_data;
    assign pkt_end       = r_pkt_end;
    assign pkt_crc       = r_pkt_crc;
    assign pkt_abort     = r_pkt_abort;
    assign sync_err      = r_sync_err;

endmodule

// File: tb/tb_mipi_hs_burst_ctrl.sv
// tb_mipi_hs_burst_ctrl: scoreboard bench for the HS burst sequencer.
`timescale 1ns/1ps
module tb_mipi_hs_burst_ctrl;

    localparam int K_HDR = 0, K_PL = 1, K_END = 2, K_ABORT = 3, K_SERR = 4;

    typedef struct {
        int          kind;
        logic [31:0] val;
        bit          chk;
    } ev_t;

    logic        byte_clk = 1'b0;
    logic        sys_rst_n = 1'b0;
    logic        hs_active = 1'b0;
    logic        aligned_valid = 1'b0;
    logic [7:0]  aligned_data = 8'd0;
    logic        align_rst_n, pkt_hdr_valid, pkt_long, ecc_err, pl_valid;
    logic        pkt_end, pkt_abort, sync_err;
    logic [7:0]  pkt_di, pl_data;
    logic [15:0] pkt_wc, pkt_crc;

    ev_t         sb[$];
    int          n_checks = 0;
    int          n_fail = 0;
    logic [7:0]  pl_buf [64];
    logic [15:0] crc_val;

    mipi_hs_burst_ctrl #(.SYNC_TIMEOUT(64)) dut (
        .byte_clk      (byte_clk),
        .sys_rst_n     (sys_rst_n),
        .hs_active     (hs_active),
        .aligned_valid (aligned_valid),
        .aligned_data  (aligned_data),
        .align_rst_n   (align_rst_n),
        .pkt_hdr_valid (pkt_hdr_valid),
        .pkt_di        (pkt_di),
        .pkt_wc        (pkt_wc),
        .pkt_long      (pkt_long),
        .ecc_err       (ecc_err),
        .pl_valid      (pl_valid),
        .pl_data       (pl_data),
        .pkt_end       (pkt_end),
        .pkt_crc       (pkt_crc),
        .pkt_abort     (pkt_abort),
        .sync_err      (sync_err)
    );

    always #5 byte_clk = ~byte_clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // Reference: DSI Hamming parity equations over D[23:0] = {WC_H, WC_L, DI}
    function automatic logic [5:0] ref_ecc(input logic [23:0] d);
        logic [5:0] p;
        p[0] = d[0]^d[1]^d[2]^d[4]^d[5]^d[7]^d[10]^d[11]^d[13]^d[16]^d[20]^d[21]^d[22]^d[23];
        p[1] = d[0]^d[1]^d[3]^d[4]^d[6]^d[8]^d[10]^d[12]^d[14]^d[17]^d[20]^d[21]^d[22]^d[23];
        p[2] = d[0]^d[2]^d[3]^d[5]^d[6]^d[9]^d[11]^d[12]^d[15]^d[18]^d[20]^d[21]^d[22];
        p[3] = d[1]^d[2]^d[3]^d[7]^d[8]^d[9]^d[13]^d[14]^d[15]^d[19]^d[20]^d[21]^d[23];
        p[4] = d[4]^d[5]^d[6]^d[7]^d[8]^d[9]^d[16]^d[17]^d[18]^d[19]^d[20]^d[22]^d[23];
        p[5] = d[10]^d[11]^d[12]^d[13]^d[14]^d[15]^d[16]^d[17]^d[18]^d[19]^d[21]^d[22]^d[23];
        return p;
    endfunction

    function automatic logic ref_long(input logic [7:0] di);
        logic [3:0] n;
        n = di[3:0];
        return (n == 4'h9) || (n == 4'hC) || (n == 4'hD) || (n == 4'hE);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic push(input int kind, input logic [31:0] val, input bit c);
        ev_t e;
        e.kind = kind;
        e.val  = val;
        e.chk  = c;
        sb.push_back(e);
    endtask

    task automatic mon_pop(input int kind, input logic [31:0] val, input string nm);
        ev_t e;
        n_checks++;
        if (sb.size() == 0) begin
            n_fail++;
            $display("FAIL %s: strobe with value 0x%0h, expected no strobe", nm, val);
        end else begin
            e = sb.pop_front();
            if (e.kind != kind || (e.chk && e.val !== val)) begin
                n_fail++;
                $display("FAIL %s: got kind %0d value 0x%0h, expected kind %0d value 0x%0h",
                         nm, kind, val, e.kind, e.val);
            end
        end
    endtask

    // Monitor: pops one expected event per output strobe, away from the active edge
    always @(negedge byte_clk) begin
        if (sys_rst_n) begin
            if (pkt_hdr_valid) mon_pop(K_HDR, {6'd0, ecc_err, pkt_long, pkt_di, pkt_wc}, "hdr");
            if (pl_valid)      mon_pop(K_PL, {24'd0, pl_data}, "payload");
            if (pkt_end)       mon_pop(K_END, {16'd0, pkt_crc}, "pkt_end");
            if (pkt_abort)     mon_pop(K_ABORT, 32'd0, "pkt_abort");
            if (sync_err)      mon_pop(K_SERR, 32'd0, "sync_err");
        end
    end

    task automatic step();
        @(posedge byte_clk);
        #1;
    endtask

    // One valid byte preceded by 0..2 idle cycles carrying garbage data
    task automatic send_byte(input logic [7:0] b, input logic hs_with);
        int g;
        g = int'($urandom_range(0, 2));
        for (int i = 0; i < g; i++) begin
            aligned_valid = 1'b0;
            aligned_data  = 8'($urandom);
            step();
        end
        aligned_valid = 1'b1;
        aligned_data  = b;
        hs_active     = hs_with;
        step();
        aligned_valid = 1'b0;
    endtask

    // Sends a packet (payload from pl_buf, CRC from crc_val), pushing expected events.
    // cut >= 0 sends only that many bytes; in_long reports a cut inside a long packet body.
    task automatic send_pkt(input logic [7:0] di, input logic [15:0] wc, input int cut,
                            input logic [7:0] flip, input bit drop_last, output bit in_long);
        logic       lng;
        logic       ecc_exp;
        logic [7:0] ecc;
        logic [7:0] bytes[$];
        int         total;
        lng = ref_long(di);
        ecc = {2'b00, ref_ecc({wc, di})} ^ flip;
`ifdef MIPI_BURST_ECC_EN
        ecc_exp = (flip != 8'd0);
`else
        ecc_exp = 1'b0;
`endif
        bytes.delete();
        bytes.push_back(di);
        bytes.push_back(wc[7:0]);
        bytes.push_back(wc[15:8]);
        bytes.push_back(ecc);
        if (lng) begin
            for (int i = 0; i < int'(wc); i++) bytes.push_back(pl_buf[i]);
            bytes.push_back(crc_val[7:0]);
            bytes.push_back(crc_val[15:8]);
        end
        total = bytes.size();
        for (int k = 0; k < total; k++) begin
            if (cut >= 0 && k >= cut) break;
            if (k == 3) begin
                push(K_HDR, {6'd0, ecc_exp, lng, di, wc}, 1'b1);
                if (!lng) push(K_END, 32'd0, 1'b0);
            end else if (lng && k >= 4 && k < total - 2) begin
                push(K_PL, {24'd0, bytes[k]}, 1'b1);
            end else if (lng && k == total - 1) begin
                push(K_END, {16'd0, crc_val}, 1'b1);
            end
            send_byte(bytes[k], (drop_last && k == total - 1) ? 1'b0 : 1'b1);
        end
        in_long = lng && cut >= 4 && cut < total;
    endtask

    task automatic start_burst();
        int g;
        hs_active     = 1'b1;
        aligned_valid = 1'b0;
        step();
        chk("align_rst_n rise", 32'(align_rst_n), 32'd1);
        g = int'($urandom_range(0, 4));
        for (int i = 0; i < g; i++) step();
        send_byte(8'hB8, 1'b1);
    endtask

    task automatic end_burst();
        aligned_valid = 1'b0;
        hs_active     = 1'b0;
        step();
        chk("align_rst_n fall", 32'(align_rst_n), 32'd0);
        step();
        step();
    endtask

    task automatic random_burst();
        int         np, total, cut;
        bit         inl;
        logic [7:0] di, flip;
        logic [15:0] wc;
        np  = int'($urandom_range(1, 4));
        inl = 1'b0;
        start_burst();
        for (int p = 0; p < np; p++) begin
            di = 8'($urandom);
            if (ref_long(di)) wc = 16'($urandom_range(0, 6));
            else              wc = 16'($urandom);
            for (int i = 0; i < 8; i++) pl_buf[i] = 8'($urandom);
            crc_val = 16'($urandom);
            total = 4 + (ref_long(di) ? int'(wc) + 2 : 0);
            cut = -1;
            if (p == np - 1 && $urandom_range(0, 3) == 0) cut = int'($urandom_range(0, total - 1));
            flip = ($urandom_range(0, 3) == 0) ? 8'(1 << $urandom_range(0, 7)) : 8'd0;
            send_pkt(di, wc, cut, flip, 1'b0, inl);
        end
        if (inl) push(K_ABORT, 32'd0, 1'b0);
        end_burst();
    endtask

    initial begin
        bit inl;
        int hi;

        // Reset state
        step();
        step();
        chk("reset align_rst_n", 32'(align_rst_n), 32'd0);
        chk("reset strobes", {26'd0, pkt_hdr_valid, pl_valid, pkt_end, pkt_abort, sync_err, ecc_err}, 32'd0);
        chk("reset pkt_di", 32'(pkt_di), 32'd0);
        chk("reset pkt_wc", 32'(pkt_wc), 32'd0);
        chk("reset pkt_crc", 32'(pkt_crc), 32'd0);
        chk("reset pl_data/long", {23'd0, pkt_long, pl_data}, 32'd0);
        sys_rst_n = 1'b1;
        step();
        chk("idle align_rst_n", 32'(align_rst_n), 32'd0);

        // Short packet DI=0x05, data 0x11,0x00
        start_burst();
        send_pkt(8'h05, 16'h0011, -1, 8'h00, 1'b0, inl);
        end_burst();

        // Long packet DI=0x39, WC=3, CRC 0x1234
        pl_buf[0] = 8'hAA; pl_buf[1] = 8'hBB; pl_buf[2] = 8'hCC;
        crc_val = 16'h1234;
        start_burst();
        send_pkt(8'h39, 16'd3, -1, 8'h00, 1'b0, inl);
        end_burst();

        // Back-to-back short then long WC=2 in one burst
        start_burst();
        send_pkt(8'h15, 16'h5A29, -1, 8'h00, 1'b0, inl);
        chk("align held after short", 32'(align_rst_n), 32'd1);
        pl_buf[0] = 8'h01; pl_buf[1] = 8'hFE; crc_val = 16'hBEEF;
        send_pkt(8'h29, 16'd2, -1, 8'h00, 1'b0, inl);
        chk("align held after long", 32'(align_rst_n), 32'd1);
        end_burst();

        // hs_active falls after the first of five payload bytes
        for (int i = 0; i < 5; i++) pl_buf[i] = 8'(8'h40 + i);
        crc_val = 16'h0F0F;
        start_burst();
        send_pkt(8'h39, 16'd5, 5, 8'h00, 1'b0, inl);
        chk("abort flagged by model", 32'(inl), 32'd1);
        if (inl) push(K_ABORT, 32'd0, 1'b0);
        end_burst();

        // No valid byte: sync timeout after 64 cycles, aligner held until hs_active falls
        push(K_SERR, 32'd0, 1'b0);
        hs_active     = 1'b1;
        aligned_valid = 1'b0;
        step();
        hi = 0;
        for (int i = 0; i < 200 && align_rst_n; i++) begin
            hi++;
            step();
        end
        chk("sync timeout cycles", 32'(hi), 32'd64);
        chk("sync_err with align fall", 32'(sync_err), 32'd1);
        for (int i = 0; i < 10; i++) step();
        chk("align low in done", 32'(align_rst_n), 32'd0);
        end_burst();

        // hs_active falls on the last CRC byte: pkt_end, no abort
        pl_buf[0] = 8'h77; crc_val = 16'hC3A5;
        start_burst();
        send_pkt(8'h2C, 16'd1, -1, 8'h00, 1'b1, inl);
        end_burst();

        // Header ECC bit 0 flipped; payload still framed by received WC
        pl_buf[0] = 8'h12; pl_buf[1] = 8'h34; crc_val = 16'h5678;
        start_burst();
        send_pkt(8'h29, 16'd2, -1, 8'h01, 1'b0, inl);
        end_burst();

        // Randomized bursts
        for (int b = 0; b < 30; b++) random_burst();

        // Asynchronous reset in the middle of a long packet: no abort strobe
        for (int i = 0; i < 6; i++) pl_buf[i] = 8'($urandom);
        crc_val = 16'h2222;
        start_burst();
        send_pkt(8'h1E, 16'd6, 6, 8'h00, 1'b0, inl);
        step();
        #2;
        sys_rst_n = 1'b0;
        #1;
        chk("async rst align_rst_n", 32'(align_rst_n), 32'd0);
        chk("async rst pkt_di", 32'(pkt_di), 32'd0);
        chk("async rst pkt_wc/pl_data", {8'd0, pkt_wc, pl_data}, 32'd0);
        hs_active = 1'b0;
        step();
        step();
        sys_rst_n = 1'b1;
        step();
        step();

        step();
        chk("scoreboard drained", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
